// File: rtl/store_trace_pkg.sv
// Shared types and constants for the store trace buffer.
package store_trace_pkg;

    // One captured store: byte address plus the data written.
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } store_entry_t;

    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extended pointers; the extra MSB tells full from empty.
module sync_fifo
    import store_trace_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = store_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 wdata,
    input  logic                   pop,
    output entry_t                 rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Qualify requests: pop only with data held, push when space exists or a pop frees a slot.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
        do_pop  = 1'b0;
        do_push = 1'b0;
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Pointer advance; the wrap into the MSB is what distinguishes full from empty.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/store_trace_buffer.sv
// Taps the processor store bus, queues stores inside an address window and
// drains them over a valid/ready port. Never back-pressures the store path.
module store_trace_buffer
    import store_trace_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter logic [31:0] FILTER_BASE = 32'h0000_0000,
    parameter logic [31:0] FILTER_MASK = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   MemWrite,
    input  logic [31:0]            Adr,
    input  logic [31:0]            WriteData,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_adr,
    output logic [31:0]            out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [DROP_CNT_W-1:0]  drop_count,
    input  logic                   clr_overflow
);

    localparam logic [31:0] BASE_MASKED = FILTER_BASE & FILTER_MASK;

    store_entry_t head;
    store_entry_t new_entry;
    logic         fifo_full;
    logic         fifo_empty;
    logic         match;
    logic         pop;
    logic         push;
    logic         drop;

    // Window match, handshake and drop decision for the current store.
    always_comb begin
        match     = MemWrite && ((Adr & FILTER_MASK) == BASE_MASKED);
        pop       = out_valid && out_ready;
        push      = match && (!fifo_full || pop);
        drop      = match && fifo_full && !pop;
        new_entry = '{adr: Adr, data: WriteData};
    end

    sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (store_entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (new_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign out_valid = !fifo_empty;
    assign out_adr   = head.adr;
    assign out_data  = head.data;

    // Sticky overflow flag and saturating drop counter; a clear beats a same-cycle drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clr_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != DROP_CNT_MAX) drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: doc/store_trace_buffer.md
# store_trace_buffer

Captures every processor store driven toward shared memory (`MemWrite`, `Adr`, `WriteData`) that falls inside a configurable address window. Each captured store is queued in a small synchronous FIFO, and the FIFO drains over a valid/ready port to an external logger or host. The block sits directly downstream of the processor/memory top level and taps the same store bus the memory consumes. It is purely observational: it never stalls or alters the memory path.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `FILTER_BASE`, 32'h0000_0000, window base address
- `FILTER_MASK`, 32'h0000_0000, address bits compared; 0 = capture all stores
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `MemWrite`  in  1  store strobe; one store per high cycle
- `Adr`  in  32  store byte address
- `WriteData`  in  32  store data
- `out_valid`  out  1  head entry available
- `out_ready`  in  1  consumer accepts head entry
- `out_adr`  out  32  head entry address
- `out_data`  out  32  head entry data
- `count`  out  $clog2(DEPTH)+1  entries held
- `overflow`  out  1  sticky: a matching store was dropped
- `drop_count`  out  8  dropped matching stores, saturating at 255
- `clr_overflow`  in  1  clears `overflow` and `drop_count`

## Operation
- Match condition: `MemWrite && ((Adr & FILTER_MASK) == (FILTER_BASE & FILTER_MASK))`.
- Push: a matching store writes {Adr, WriteData} to the tail when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Pop: `out_valid && out_ready` advances the head.
- Drop: a matching store arrives while the FIFO is full and no pop occurs.
  - The entry is discarded.
  - `overflow` is set to 1.
  - `drop_count` increments and saturates at 255.
- `clr_overflow` concurrent with a drop: the clear wins for `overflow`, and `drop_count` becomes 0. That drop is lost and is not counted.
- Order: first-in, first-out. Pointers wrap modulo `DEPTH`.
- Count update:
  - +1 on push only
  - −1 on pop only
  - unchanged on simultaneous push and pop
- Empty FIFO: simultaneous push and pop cannot occur, because `out_valid` is low. The push is taken alone.
- Non-matching stores and cycles with `MemWrite` low have no effect.
- `out_adr` and `out_data` are don't-care while `out_valid` is 0.

## Timing
- Reset values:
  - `out_valid`, `count`, `overflow`, `drop_count` = 0
  - pointers = 0
  - FIFO contents are not reset
- Capture latency: a store sampled at edge N appears at the head after edge N when the FIFO was empty. `out_valid` is high in cycle N+1.
- No combinational path from `MemWrite`, `Adr` or `WriteData` to any output. All outputs are registered or driven from storage through the head pointer.
- `out_valid` and head data stay stable until popped.
- A pop at edge N exposes the next entry in cycle N+1.
- Full FIFO with push and pop in the same cycle: both happen, no drop, `count` stays at `DEPTH`.
- Reset mid-operation empties the FIFO in one cycle. A `MemWrite` during reset is ignored.
- `count` ranges from 0 to `DEPTH` inclusive.

## Structure
- Package `store_trace_pkg`:
  - `typedef struct packed {logic [31:0] adr; logic [31:0] data;} store_entry_t`
  - `DROP_CNT_W = 8`
- Sub-module `sync_fifo`:
  - parameterised by `DEPTH` and the entry type
  - provides push, pop, full, empty, count
  - pointers are `$clog2(DEPTH)+1` bits wide, with the MSB distinguishing full from empty
- Top of this block: match filter, drop/overflow logic, port mapping.

## Test plan
1. Reset, then stores (0x64, 7) and (0x68, 9) with `out_ready`=0 → `count`=2, head is (0x64, 7); raising `out_ready` yields (0x68, 9) next, then `out_valid`=0.
2. `FILTER_BASE`=0x100, `FILTER_MASK`=0xFFFF_FF00; stores to 0x0FC, 0x104, 0x1FC, 0x200 → only 0x104 and 0x1FC are queued.
3. `DEPTH`=8, `out_ready`=0, 10 matching stores → `count`=8, `overflow`=1, `drop_count`=2, and the entries held are the first 8 in order.
4. Full FIFO with a store and `out_ready`=1 in the same cycle → no drop, `count` stays 8, and the new entry lands last.
5. 300 drops → `drop_count`=255; `clr_overflow` pulse → `overflow`=0, `drop_count`=0, and queued entries are unaffected.
6. Assert `reset` with 5 entries queued and a concurrent `MemWrite` → next cycle `count`=0, `out_valid`=0, `overflow`=0.
